// File: rtl/laser_pkg.sv
// Shared types and sizing helpers for the two-circle coverage optimiser.
package laser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP1,
    ST_SWEEP2,
    ST_CHECK,
    ST_OUT
  } state_t;

  localparam int DEF_N_PTS    = 40;
  localparam int DEF_COORD_W  = 4;
  localparam int DEF_RADIUS   = 4;
  localparam int DEF_MAX_ITER = 8;

  function automatic int grid_side(input int cw);
    return 1 << cw;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int sqd_width(input int cw);
    return 2 * cw + 1;
  endfunction

  function automatic logic [31:0] radius_sq(input int r);
    return 32'(r * r);
  endfunction

  localparam int G     = grid_side(DEF_COORD_W);
  localparam int CNT_W = cnt_width(DEF_N_PTS);
  localparam int SQD_W = sqd_width(DEF_COORD_W);

endpackage

// File: rtl/laser_in_circle.sv
// Combinational test: is point (px,py) within RADIUS of centre (cx,cy).
module laser_in_circle
  import laser_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int RADIUS  = DEF_RADIUS
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic               hit
);

  localparam int          SQ_W = sqd_width(COORD_W);
  localparam logic [31:0] R_SQ = radius_sq(RADIUS);

  logic [COORD_W-1:0]   dx, dy;
  logic [2*COORD_W-1:0] dx2, dy2;
  logic [SQ_W-1:0]      dsum;

  always_comb begin
    dx   = (px >= cx) ? px - cx : cx - px;
    dy   = (py >= cy) ? py - cy : cy - py;
    dx2  = (2*COORD_W)'(dx) * (2*COORD_W)'(dx);
    dy2  = (2*COORD_W)'(dy) * (2*COORD_W)'(dy);
    dsum = SQ_W'(dx2) + SQ_W'(dy2);
    // compared at 32 bits so a large RADIUS cannot wrap
    hit  = (32'(dsum) <= R_SQ);
  end

endmodule

// File: rtl/laser_cover_opt.sv
// Two-circle coverage optimiser: loads N_PTS points, alternates exhaustive C1/C2 sweeps.
// Define LASER_EARLY_EXIT_EN to stop once a full round brings no improvement.
module laser_cover_opt
  import laser_pkg::*;
#(
  parameter int N_PTS    = DEF_N_PTS,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int RADIUS   = DEF_RADIUS,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  input  logic [COORD_W-1:0]           X,
  input  logic [COORD_W-1:0]           Y,
  output logic                         IN_READY,
  output logic [COORD_W-1:0]           C1X,
  output logic [COORD_W-1:0]           C1Y,
  output logic [COORD_W-1:0]           C2X,
  output logic [COORD_W-1:0]           C2Y,
  output logic [$clog2(N_PTS+1)-1:0]   COVER,
  output logic                         DONE
);

  localparam int CNT_W = cnt_width(N_PTS);
  localparam int RND_W = $clog2(MAX_ITER + 1);
  localparam int GSQ   = grid_side(COORD_W) * grid_side(COORD_W);

  state_t state, state_nx;

  logic [2*COORD_W-1:0] mem [N_PTS];
  logic [CNT_W-1:0]     load_cnt, pt_idx, acc, best_cnt, start_cnt, total;
  logic [2*COORD_W-1:0] cand;
  logic [RND_W-1:0]     round, round_inc;
  logic [COORD_W-1:0]   c1x, c1y, c2x, c2y;
  logic [COORD_W-1:0]   px, py, fx, fy;
  logic                 hit_c, hit_f, hit, other_valid;
  logic                 accept, load_full, last_pt, last_cand, exit_now;

  assign load_full = (load_cnt == CNT_W'(N_PTS));
  assign IN_READY  = ((state == ST_IDLE) || (state == ST_LOAD)) && !load_full;
  assign accept    = IN_VALID && IN_READY;
  assign last_pt   = (pt_idx == CNT_W'(N_PTS - 1));
  assign last_cand = (cand == (2*COORD_W)'(GSQ - 1));
  assign {px, py}  = mem[pt_idx];

  // fixed circle is whichever centre is not being swept
  assign fx          = (state == ST_SWEEP1) ? c2x : c1x;
  assign fy          = (state == ST_SWEEP1) ? c2y : c1y;
  assign other_valid = (state == ST_SWEEP2) || (round != '0);
  assign hit         = hit_c || (other_valid && hit_f);
  assign total       = acc + CNT_W'(hit);
  assign round_inc   = round + 1'b1;

`ifdef LASER_EARLY_EXIT_EN
  assign exit_now = (round_inc == RND_W'(MAX_ITER)) ||
                    ((round != '0) && (best_cnt == start_cnt));
`else
  assign exit_now = (round_inc == RND_W'(MAX_ITER));
`endif

  laser_in_circle #(.COORD_W(COORD_W), .RADIUS(RADIUS)) u_cand (
    .px (px),
    .py (py),
    .cx (cand[COORD_W-1:0]),
    .cy (cand[2*COORD_W-1:COORD_W]),
    .hit(hit_c)
  );

  laser_in_circle #(.COORD_W(COORD_W), .RADIUS(RADIUS)) u_fixed (
    .px (px),
    .py (py),
    .cx (fx),
    .cy (fy),
    .hit(hit_f)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_LOAD;
      ST_LOAD:   if (load_full) state_nx = ST_SWEEP1;
      ST_SWEEP1: if (last_pt && last_cand) state_nx = ST_SWEEP2;
      ST_SWEEP2: if (last_pt && last_cand) state_nx = ST_CHECK;
      ST_CHECK:  state_nx = exit_now ? ST_OUT : ST_SWEEP1;
      ST_OUT:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // point memory is deliberately left out of reset
  always_ff @(posedge CLK) begin
    if (accept) mem[load_cnt] <= {X, Y};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_cnt  <= '0;
      pt_idx    <= '0;
      acc       <= '0;
      cand      <= '0;
      round     <= '0;
      best_cnt  <= '0;
      start_cnt <= '0;
      c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
      C1X <= '0; C1Y <= '0; C2X <= '0; C2Y <= '0;
      COVER <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) load_cnt <= load_cnt + 1'b1;
        end
        ST_LOAD: begin
          if (accept) load_cnt <= load_cnt + 1'b1;
          if (load_full) begin
            load_cnt  <= '0;
            pt_idx    <= '0;
            acc       <= '0;
            cand      <= '0;
            round     <= '0;
            best_cnt  <= '0;
            start_cnt <= '0;
            c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
          end
        end
        ST_SWEEP1, ST_SWEEP2: begin
          if (last_pt) begin
            acc    <= '0;
            pt_idx <= '0;
            cand   <= cand + 1'b1;
            // strict compare keeps the incumbent on ties
            if (total > best_cnt) begin
              best_cnt <= total;
              if (state == ST_SWEEP1) begin
                c1x <= cand[COORD_W-1:0];
                c1y <= cand[2*COORD_W-1:COORD_W];
              end else begin
                c2x <= cand[COORD_W-1:0];
                c2y <= cand[2*COORD_W-1:COORD_W];
              end
            end
          end else begin
            acc    <= total;
            pt_idx <= pt_idx + 1'b1;
          end
        end
        ST_CHECK: begin
          round     <= round_inc;
          start_cnt <= best_cnt;
        end
        ST_OUT: begin
          C1X   <= c1x;
          C1Y   <= c1y;
          C2X   <= c2x;
          C2Y   <= c2y;
          COVER <= best_cnt;
          DONE  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
